// File: rtl/feedback_loop_inverse_if.sv
// Valid/ready stream bundle for feedback_loop_inverse: y samples in, x samples out,
// plus the delivered-sample counter. The decoder connects to the slave modport and
// the source/consumer side uses master.
interface feedback_loop_inverse_if #(
    parameter int W     = 8,
    parameter int CNT_W = 16
);
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] in_data;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] out_data;
    logic [CNT_W-1:0]    sample_cnt;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  sample_cnt
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output sample_cnt
    );
endinterface

// File: rtl/feedback_loop_inverse.sv
// feedback_loop_inverse: recovers x[n] = y[n] - (y[n-1] >>> LEAK_SHIFT) mod 2^W from
// the feedback-loop output stream. A 2-entry skid buffer (head register + skid)
// keeps full throughput while in_ready stays a registered output.
// Optional feature macro: FEEDBACK_INV_RESYNC_EN adds the resync input, which clears
// the decode history after the current cycle's accept without touching buffered data.
module feedback_loop_inverse #(
    parameter int W          = 8,
    parameter int LEAK_SHIFT = 0,
    parameter int CNT_W      = 16
) (
    input  logic                  system1000,
    input  logic                  system1000_rst,
`ifdef FEEDBACK_INV_RESYNC_EN
    input  logic                  resync,
`endif
    feedback_loop_inverse_if.slave bus
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic signed [W-1:0] y_prev_q, y_prev_d;
    logic signed [W-1:0] out_q, out_d;
    logic signed [W-1:0] skid_q, skid_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                accept_s;
    logic                pop_s;
    logic signed [W-1:0] x_s;

    assign accept_s = bus.in_valid & in_ready_q;
    assign pop_s    = out_valid_q & bus.out_ready;
    // Wrap-around subtraction: no saturation, the result is simply truncated to W bits.
    assign x_s      = bus.in_data - (y_prev_q >>> LEAK_SHIFT);

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_q;
    assign bus.sample_cnt = cnt_q;

    // Decode history: follows accepted y only; resync clears it after this cycle's accept.
    always_comb begin
        y_prev_d = y_prev_q;
        if (accept_s) begin
            y_prev_d = bus.in_data;
        end else begin
            y_prev_d = y_prev_q;
        end
`ifdef FEEDBACK_INV_RESYNC_EN
        if (resync) begin
            y_prev_d = {W{1'b0}};
        end else begin
            y_prev_d = y_prev_d;
        end
`endif
    end

    // Skid-buffer next state, data movement and registered handshake outputs.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept_s) begin
                    out_d   = x_s;
                    state_d = ST_ONE;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (accept_s && pop_s) begin
                    out_d   = x_s;
                    state_d = ST_ONE;
                end else if (accept_s) begin
                    skid_d  = x_s;
                    state_d = ST_TWO;
                end else if (pop_s) begin
                    state_d = ST_EMPTY;
                end else begin
                    state_d = ST_ONE;
                end
            end
            ST_TWO: begin
                if (pop_s) begin
                    out_d   = skid_q;
                    state_d = ST_ONE;
                end else begin
                    state_d = ST_TWO;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        in_ready_d  = (state_d != ST_TWO);
        out_valid_d = (state_d != ST_EMPTY);
        cnt_d       = cnt_q + {{(CNT_W-1){1'b0}}, pop_s};
    end

    // State and datapath registers; async reset discards buffered samples and history.
    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) begin
            state_q     <= ST_EMPTY;
            y_prev_q    <= {W{1'b0}};
            out_q       <= {W{1'b0}};
            skid_q      <= {W{1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            cnt_q       <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            y_prev_q    <= y_prev_d;
            out_q       <= out_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_feedback_loop_inverse.sv
// Directed bench for feedback_loop_inverse: dut0 (LEAK_SHIFT=0, CNT_W=16) carries most
// scenarios; dut1 (LEAK_SHIFT=1, CNT_W=2) covers the leak shift and counter wrap.
module tb_feedback_loop_inverse;

    logic clk;
    logic rst;
`ifdef FEEDBACK_INV_RESYNC_EN
    logic resync0;
    logic resync1;
`endif

    int pass_cnt;
    int total_cnt;

    feedback_loop_inverse_if #(.W(8), .CNT_W(16)) bus0 ();
    feedback_loop_inverse_if #(.W(8), .CNT_W(2))  bus1 ();

    feedback_loop_inverse #(.W(8), .LEAK_SHIFT(0), .CNT_W(16)) dut0 (
        .system1000     (clk),
        .system1000_rst (rst),
`ifdef FEEDBACK_INV_RESYNC_EN
        .resync         (resync0),
`endif
        .bus            (bus0)
    );

    feedback_loop_inverse #(.W(8), .LEAK_SHIFT(1), .CNT_W(2)) dut1 (
        .system1000     (clk),
        .system1000_rst (rst),
`ifdef FEEDBACK_INV_RESYNC_EN
        .resync         (resync1),
`endif
        .bus            (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus0.in_valid  = 1'b0;
        bus0.in_data   = 8'sd0;
        bus0.out_ready = 1'b1;
        bus1.in_valid  = 1'b0;
        bus1.in_data   = 8'sd0;
        bus1.out_ready = 1'b1;
`ifdef FEEDBACK_INV_RESYNC_EN
        resync0 = 1'b0;
        resync1 = 1'b0;
`endif
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        #1;
        total_cnt++;
        if (bus0.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus0.out_valid);
        else pass_cnt++;
        total_cnt++;
        if (bus0.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus0.in_ready);
        else pass_cnt++;
        total_cnt++;
        if (bus0.out_data !== 8'sd0) $display("FAIL reset_out_data: got %0d want 0", bus0.out_data);
        else pass_cnt++;
        total_cnt++;
        if (bus0.sample_cnt !== 16'd0) $display("FAIL reset_cnt: got %0d want 0", bus0.sample_cnt);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int ys[3] = '{5, 8, 6};
        int xs[3] = '{5, 3, -2};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                total_cnt++;
                if (bus0.out_valid !== 1'b1 || bus0.out_data !== 8'(xs[i-1]))
                    $display("FAIL basic_x%0d: got v=%b %0d want v=1 %0d", i - 1, bus0.out_valid, bus0.out_data, xs[i-1]);
                else pass_cnt++;
            end
            if (i < 3) begin
                bus0.in_valid = 1'b1;
                bus0.in_data  = 8'(ys[i]);
            end else begin
                bus0.in_valid = 1'b0;
            end
            @(negedge clk);
        end
        total_cnt++;
        if (bus0.sample_cnt !== 16'd3 || bus0.out_valid !== 1'b0)
            $display("FAIL basic_cnt: got cnt=%0d v=%b want cnt=3 v=0", bus0.sample_cnt, bus0.out_valid);
        else pass_cnt++;
    endtask

    task automatic test_wrap_and_leak();
        int y0[5] = '{127, -128, 0, 0, 0};
        int x0[5] = '{127, 1, -128, 0, 0};
        int y1[5] = '{10, 9, -7, 0, 3};
        int x1[5] = '{10, 4, -11, 4, 3};
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            if (i > 0) begin
                total_cnt++;
                if (bus0.out_valid !== 1'b1 || bus0.out_data !== 8'(x0[i-1]))
                    $display("FAIL wrap_x%0d: got v=%b %0d want v=1 %0d", i - 1, bus0.out_valid, bus0.out_data, x0[i-1]);
                else pass_cnt++;
                total_cnt++;
                if (bus1.out_valid !== 1'b1 || bus1.out_data !== 8'(x1[i-1]))
                    $display("FAIL leak_x%0d: got v=%b %0d want v=1 %0d", i - 1, bus1.out_valid, bus1.out_data, x1[i-1]);
                else pass_cnt++;
            end
            if (i < 5) begin
                bus0.in_valid = 1'b1;
                bus0.in_data  = 8'(y0[i]);
                bus1.in_valid = 1'b1;
                bus1.in_data  = 8'(y1[i]);
            end else begin
                bus0.in_valid = 1'b0;
                bus1.in_valid = 1'b0;
            end
            @(negedge clk);
        end
        total_cnt++;
        if (bus0.sample_cnt !== 16'd5) $display("FAIL wrap_cnt: got %0d want 5", bus0.sample_cnt);
        else pass_cnt++;
        total_cnt++;
        if (bus1.sample_cnt !== 2'd1) $display("FAIL cnt_wrap: got %0d want 1", bus1.sample_cnt);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        apply_reset();
        bus0.out_ready = 1'b0;
        bus0.in_valid  = 1'b1;
        bus0.in_data   = 8'sd10;
        @(negedge clk);
        total_cnt++;
        if (bus0.out_valid !== 1'b1 || bus0.out_data !== 8'sd10 || bus0.in_ready !== 1'b1)
            $display("FAIL bp_one: got v=%b d=%0d rdy=%b want v=1 d=10 rdy=1", bus0.out_valid, bus0.out_data, bus0.in_ready);
        else pass_cnt++;
        bus0.in_data = 8'sd30;
        @(negedge clk);
        total_cnt++;
        if (bus0.in_ready !== 1'b0 || bus0.out_data !== 8'sd10)
            $display("FAIL bp_two: got rdy=%b d=%0d want rdy=0 d=10", bus0.in_ready, bus0.out_data);
        else pass_cnt++;
        bus0.in_data = 8'sd25;
        @(negedge clk);
        total_cnt++;
        if (bus0.in_ready !== 1'b0 || bus0.out_data !== 8'sd10 || bus0.out_valid !== 1'b1)
            $display("FAIL bp_hold: got rdy=%b d=%0d v=%b want rdy=0 d=10 v=1", bus0.in_ready, bus0.out_data, bus0.out_valid);
        else pass_cnt++;
        bus0.out_ready = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (bus0.out_data !== 8'sd20 || bus0.in_ready !== 1'b1)
            $display("FAIL bp_skid: got d=%0d rdy=%b want d=20 rdy=1", bus0.out_data, bus0.in_ready);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (bus0.out_valid !== 1'b1 || bus0.out_data !== -8'sd5)
            $display("FAIL bp_third: got v=%b d=%0d want v=1 d=-5", bus0.out_valid, bus0.out_data);
        else pass_cnt++;
        bus0.in_valid = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (bus0.out_valid !== 1'b0 || bus0.sample_cnt !== 16'd3)
            $display("FAIL bp_drain: got v=%b cnt=%0d want v=0 cnt=3", bus0.out_valid, bus0.sample_cnt);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic signed [7:0] exp_q[$];
        logic signed [7:0] ref_y;
        logic signed [7:0] cur_x;
        logic signed [7:0] cur_y;
        logic signed [7:0] exp_x;
        int sent;
        int popped;
        int cycles;
        apply_reset();
        ref_y  = 8'sd0;
        cur_x  = 8'($urandom);
        cur_y  = cur_x + ref_y;
        sent   = 0;
        popped = 0;
        cycles = 0;
        while (popped < 1000 && cycles < 20000) begin
            bus0.in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            bus0.in_data   = cur_y;
            bus0.out_ready = ($urandom_range(0, 2) != 0);
            if (bus0.out_valid && bus0.out_ready) begin
                total_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL rand_extra: got %0d with no sample pending", bus0.out_data);
                end else begin
                    exp_x = exp_q.pop_front();
                    if (bus0.out_data !== exp_x)
                        $display("FAIL rand_x%0d: got %0d want %0d", popped, bus0.out_data, exp_x);
                    else pass_cnt++;
                end
                popped++;
            end
            if (bus0.in_valid && bus0.in_ready) begin
                exp_q.push_back(cur_x);
                ref_y = cur_y;
                sent++;
                cur_x = 8'($urandom);
                cur_y = cur_x + ref_y;
            end
            @(negedge clk);
            cycles++;
        end
        bus0.in_valid  = 1'b0;
        bus0.out_ready = 1'b1;
        total_cnt++;
        if (popped != 1000) $display("FAIL rand_timeout: got %0d samples want 1000", popped);
        else pass_cnt++;
        total_cnt++;
        if (bus0.sample_cnt !== 16'd1000) $display("FAIL rand_cnt: got %0d want 1000", bus0.sample_cnt);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        bus0.out_ready = 1'b1;
        bus0.in_valid  = 1'b1;
        bus0.in_data   = 8'sd40;
        @(negedge clk);
        bus0.in_data = 8'sd50;
        @(negedge clk);
        bus0.out_ready = 1'b0;
        bus0.in_data   = 8'sd60;
        @(negedge clk);
        total_cnt++;
        if (bus0.in_ready !== 1'b0 || bus0.sample_cnt !== 16'd1)
            $display("FAIL mid_pre: got rdy=%b cnt=%0d want rdy=0 cnt=1", bus0.in_ready, bus0.sample_cnt);
        else pass_cnt++;
        bus0.in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (bus0.out_valid !== 1'b0 || bus0.in_ready !== 1'b1 || bus0.sample_cnt !== 16'd0)
            $display("FAIL mid_reset: got v=%b rdy=%b cnt=%0d want v=0 rdy=1 cnt=0", bus0.out_valid, bus0.in_ready, bus0.sample_cnt);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        bus0.out_ready = 1'b1;
        bus0.in_valid  = 1'b1;
        bus0.in_data   = 8'sd7;
        @(negedge clk);
        total_cnt++;
        if (bus0.out_valid !== 1'b1 || bus0.out_data !== 8'sd7)
            $display("FAIL mid_after: got v=%b d=%0d want v=1 d=7", bus0.out_valid, bus0.out_data);
        else pass_cnt++;
        bus0.in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_resync();
        apply_reset();
        bus0.out_ready = 1'b1;
        bus0.in_valid  = 1'b1;
        bus0.in_data   = 8'sd20;
        @(negedge clk);
        total_cnt++;
        if (bus0.out_data !== 8'sd20) $display("FAIL resync_first: got %0d want 20", bus0.out_data);
        else pass_cnt++;
        bus0.in_valid = 1'b0;
`ifdef FEEDBACK_INV_RESYNC_EN
        resync0 = 1'b1;
`endif
        @(negedge clk);
`ifdef FEEDBACK_INV_RESYNC_EN
        resync0 = 1'b0;
`endif
        bus0.in_valid = 1'b1;
        bus0.in_data  = 8'sd3;
        @(negedge clk);
        total_cnt++;
`ifdef FEEDBACK_INV_RESYNC_EN
        if (bus0.out_data !== 8'sd3) $display("FAIL resync_cleared: got %0d want 3", bus0.out_data);
        else pass_cnt++;
        bus0.in_data = 8'sd4;
        resync0      = 1'b1;
        @(negedge clk);
        resync0 = 1'b0;
        total_cnt++;
        if (bus0.out_data !== 8'sd1) $display("FAIL resync_same_cycle: got %0d want 1", bus0.out_data);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (bus0.out_data !== 8'sd4) $display("FAIL resync_after: got %0d want 4", bus0.out_data);
        else pass_cnt++;
`else
        if (bus0.out_data !== -8'sd17) $display("FAIL noresync_hist: got %0d want -17", bus0.out_data);
        else pass_cnt++;
`endif
        bus0.in_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst       = 1'b0;
        idle_inputs();
        test_reset();
        test_basic();
        test_wrap_and_leak();
        test_backpressure();
        test_random();
        test_reset_mid();
        test_resync();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
